// File: rtl/adder_bist_pkg.sv
// Shared types, constants and vector helpers for the adder BIST engine.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CORNER,
        RANDOM
    } state_t;

    localparam int          NUM_CORNER   = 8;
    localparam logic [15:0] NO_FAIL      = 16'hFFFF;
    localparam int          XS_SHL_A     = 13;
    localparam int          XS_SHR       = 7;
    localparam int          XS_SHL_B     = 17;
    localparam logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;

    // One stimulus vector at full 64-bit width; callers truncate to WIDTH.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
    } vec_t;

    // One step of the 64-bit xorshift generator.
    function automatic logic [63:0] xorshift_step(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        y = y ^ (y << XS_SHL_A);
        y = y ^ (y >> XS_SHR);
        y = y ^ (y << XS_SHL_B);
        return y;
    endfunction

    // Fixed corner vectors; msb depends on the operand width.
    function automatic vec_t corner_vec(input logic [2:0] idx, input int width);
        vec_t        v;
        logic [63:0] ones;
        logic [63:0] alt_a;
        logic [63:0] alt_b;
        logic [63:0] msb;
        ones  = '1;
        alt_a = 64'hAAAA_AAAA_AAAA_AAAA;
        alt_b = 64'h5555_5555_5555_5555;
        msb   = 64'd1 << (width - 1);
        case (idx)
            3'd0:    v = '{a: '0,    b: '0,    cin: 1'b0};
            3'd1:    v = '{a: '0,    b: '0,    cin: 1'b1};
            3'd2:    v = '{a: ones,  b: '0,    cin: 1'b1};
            3'd3:    v = '{a: ones,  b: ones,  cin: 1'b1};
            3'd4:    v = '{a: ones,  b: ones,  cin: 1'b0};
            3'd5:    v = '{a: alt_a, b: alt_b, cin: 1'b0};
            3'd6:    v = '{a: alt_a, b: alt_b, cin: 1'b1};
            default: v = '{a: msb,   b: msb,   cin: 1'b0};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/result bus between the BIST engine and the adder under test.
interface adder_bist_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_cin;
    logic [WIDTH-1:0] dut_s;
    logic             dut_c;

    // BIST side drives operands and reads the result.
    modport master (output dut_a, dut_b, dut_cin, input dut_s, dut_c);
    // Adder side reads operands and drives the result.
    modport slave  (input dut_a, dut_b, dut_cin, output dut_s, dut_c);
endinterface

// File: rtl/adder_bist_prng.sv
// 64-bit xorshift source; each advance consumes two successive steps.
module adder_bist_prng
    import adder_bist_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [63:0] i_seed,
    input  logic        i_advance,
    output logic [63:0] o_step1,
    output logic [63:0] o_step2
);
    logic [63:0] r_state;
    logic [63:0] w_step1;
    logic [63:0] w_step2;

    assign w_step1 = xorshift_step(r_state);
    assign w_step2 = xorshift_step(w_step1);
    assign o_step1 = w_step1;
    assign o_step2 = w_step2;

    // Generator state: seeded on reset or load, moves two steps per advance.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)
            r_state <= SEED;
        else if (i_load)
            r_state <= i_seed;
        else if (i_advance)
            r_state <= w_step2;
    end
endmodule

// File: rtl/adder_bist.sv
// BIST engine: applies corner and pseudo-random vectors to an adder and
// compares each result against a behavioural golden sum.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH      = 64,
    parameter int          SETTLE     = 1,
    parameter int          NUM_RANDOM = 256,
    parameter logic [63:0] SEED       = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    adder_bist_if.master  bus,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic [15:0]   o_err_count,
    output logic [15:0]   o_first_fail
);
    localparam logic [63:0] EFF_SEED  = (SEED == 64'd0) ? DEFAULT_SEED : SEED;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_CORNER + NUM_RANDOM - 1);
    localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [15:0]      r_idx;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [15:0]      r_err;
    logic [15:0]      r_first;

    logic [63:0]      w_step1;
    logic [63:0]      w_step2;
    logic [15:0]      w_next_idx;
    logic             w_next_random;
    vec_t             w_next_vec;
    vec_t             w_vec0;
    logic [WIDTH:0]   w_golden;
    logic             w_mismatch;
    logic             w_sample;
    logic             w_last;
    logic             w_advance;
    logic [15:0]      w_err_next;
    logic             w_unused;

    assign w_vec0        = corner_vec(3'd0, WIDTH);
    assign w_next_idx    = r_idx + 16'd1;
    assign w_next_random = (w_next_idx >= 16'(NUM_CORNER));
    assign w_sample      = (r_state != IDLE) && (r_cnt == 4'd0);
    assign w_last        = (r_idx == LAST_IDX);
    assign w_advance     = w_sample && !w_last && w_next_random;
    assign w_golden      = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    assign w_mismatch    = ({bus.dut_c, bus.dut_s} != w_golden);
    assign w_err_next    = (w_mismatch && (r_err != NO_FAIL)) ? r_err + 16'd1 : r_err;
    assign w_unused      = ^{w_step1, w_step2, w_next_vec, w_vec0};

    adder_bist_prng #(
        .SEED (EFF_SEED)
    ) u_prng (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (1'b0),
        .i_seed    (EFF_SEED),
        .i_advance (w_advance),
        .o_step1   (w_step1),
        .o_step2   (w_step2)
    );

    // Select the vector that follows the current one: corner table or PRNG.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        w_next_vec = corner_vec(w_next_idx[2:0], WIDTH);
        if (w_next_random) begin
            w_next_vec.a   = w_step1;
            w_next_vec.b   = w_step2;
            w_next_vec.cin = w_step2[63];
        end
    end

    // Run sequencer: loads vectors, samples results, keeps error statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= NO_FAIL;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (i_start && !r_done) begin
                        r_a     <= w_vec0.a[WIDTH-1:0];
                        r_b     <= w_vec0.b[WIDTH-1:0];
                        r_cin   <= w_vec0.cin;
                        r_idx   <= '0;
                        r_cnt   <= SETTLE_M1;
                        r_err   <= '0;
                        r_first <= NO_FAIL;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_state <= CORNER;
                    end
                end
                CORNER, RANDOM: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_err <= w_err_next;
                        if (w_mismatch && (r_first == NO_FAIL))
                            r_first <= r_idx;
                        if (w_last) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 16'd0);
                        end else begin
                            r_a   <= w_next_vec.a[WIDTH-1:0];
                            r_b   <= w_next_vec.b[WIDTH-1:0];
                            r_cin <= w_next_vec.cin;
                            r_idx <= w_next_idx;
                            r_cnt <= SETTLE_M1;
                            if (w_next_random)
                                r_state <= RANDOM;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dut_a    = r_a;
    assign bus.dut_b    = r_b;
    assign bus.dut_cin  = r_cin;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err;
    assign o_first_fail = r_first;
endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist: three engine instances with small, wide and
// saturating configurations, each driving a behavioural adder model.
module tb_adder_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- instance 1: WIDTH=4, SETTLE=1, NUM_RANDOM=0 ----------
    logic        rst_n1, start1, busy1, done1, pass1;
    logic [15:0] err1, ff1;
    int          mode1;
    logic [4:0]  sum1;
    adder_bist_if #(.WIDTH(4)) if1 ();
    assign sum1       = {1'b0, if1.dut_a} + {1'b0, if1.dut_b} + {4'b0, if1.dut_cin};
    assign if1.dut_s  = (mode1 == 2 && if1.dut_cin) ? (sum1[3:0] ^ 4'b0001) : sum1[3:0];
    assign if1.dut_c  = (mode1 == 1) ? 1'b0 : sum1[4];

    adder_bist #(.WIDTH(4), .SETTLE(1), .NUM_RANDOM(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .i_start(start1), .bus(if1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_count(err1), .o_first_fail(ff1)
    );

    // ---------------- instance 2: WIDTH=64, SETTLE=3, NUM_RANDOM=100 -------
    logic        rst_n2, start2, busy2, done2, pass2;
    logic [15:0] err2, ff2;
    adder_bist_if #(.WIDTH(64)) if2 ();
    assign {if2.dut_c, if2.dut_s} = {1'b0, if2.dut_a} + {1'b0, if2.dut_b} + {64'd0, if2.dut_cin};

    adder_bist #(.WIDTH(64), .SETTLE(3), .NUM_RANDOM(100)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .i_start(start2), .bus(if2),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_count(err2), .o_first_fail(ff2)
    );

    // ---------------- instance 3: WIDTH=8, always-wrong adder --------------
    logic        rst_n3, start3, busy3, done3, pass3;
    logic [15:0] err3, ff3;
    adder_bist_if #(.WIDTH(8)) if3 ();
    assign {if3.dut_c, if3.dut_s} = {1'b0, if3.dut_a} + {1'b0, if3.dut_b} + {8'd0, if3.dut_cin} + 9'd1;

    adder_bist #(.WIDTH(8), .SETTLE(1), .NUM_RANDOM(65527)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .i_start(start3), .bus(if3),
        .o_busy(busy3), .o_done(done3), .o_pass(pass3),
        .o_err_count(err3), .o_first_fail(ff3)
    );

    // Hand-written corner vectors for WIDTH=4, packed {a, b, cin}.
    function automatic logic [8:0] small_vec(input int j);
        case (j)
            0:       return {4'h0, 4'h0, 1'b0};
            1:       return {4'h0, 4'h0, 1'b1};
            2:       return {4'hF, 4'h0, 1'b1};
            3:       return {4'hF, 4'hF, 1'b1};
            4:       return {4'hF, 4'hF, 1'b0};
            5:       return {4'hA, 4'h5, 1'b0};
            6:       return {4'hA, 4'h5, 1'b1};
            default: return {4'h8, 4'h8, 1'b0};
        endcase
    endfunction

    // Corner vectors for WIDTH=64, packed {a, b, cin}.
    function automatic logic [128:0] wide_corner(input int j);
        case (j)
            0:       return {64'h0, 64'h0, 1'b0};
            1:       return {64'h0, 64'h0, 1'b1};
            2:       return {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
            3:       return {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
            4:       return {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
            5:       return {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0};
            6:       return {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1};
            default: return {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0};
        endcase
    endfunction

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // One complete run on instance 1 plus a start on the done cycle.
    task automatic run_small(input int m, input string tag, input logic [15:0] e_err,
                             input logic [15:0] e_ff, input logic e_pass);
        int bad_vec;
        int bad_busy;
        bad_vec  = 0;
        bad_busy = 0;
        mode1 = m;
        @(negedge clk) start1 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if ({if1.dut_a, if1.dut_b, if1.dut_cin} !== small_vec(j)) bad_vec++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) bad_busy++;
        end
        check({tag, "_vectors"}, 64'(bad_vec), 64'd0);
        check({tag, "_busy8"}, 64'(bad_busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done"}, {62'd0, done1, busy1}, 64'b10);
        check({tag, "_err"}, 64'(err1), 64'(e_err));
        check({tag, "_first_fail"}, 64'(ff1), 64'(e_ff));
        check({tag, "_pass"}, 64'(pass1), 64'(e_pass));
        // Start during the done cycle must be dropped.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check({tag, "_start_on_done"}, {62'd0, busy1, done1}, 64'b00);
        check({tag, "_hold_last"}, 64'({if1.dut_a, if1.dut_b, if1.dut_cin}), 64'(small_vec(7)));
        check({tag, "_pass_held"}, 64'(pass1), 64'(e_pass));
    endtask

    // One complete run on instance 2, vectors compared against a local model.
    task automatic run_wide(input string tag, inout logic [63:0] xs_state);
        int           bad_vec;
        int           bad_busy;
        logic [128:0] exp_v;
        logic [63:0]  s1;
        logic [63:0]  s2;
        bad_vec  = 0;
        bad_busy = 0;
        exp_v    = '0;
        @(negedge clk) start2 = 1'b1;
        for (int c = 0; c < 324; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (c % 3 == 0) begin
                if (c / 3 < 8) begin
                    exp_v = wide_corner(c / 3);
                end else begin
                    s1 = xs(xs_state);
                    s2 = xs(s1);
                    xs_state = s2;
                    exp_v = {s1, s2, s2[63]};
                end
            end
            if ({if2.dut_a, if2.dut_b, if2.dut_cin} !== exp_v) bad_vec++;
            if (busy2 !== 1'b1 || done2 !== 1'b0) bad_busy++;
        end
        check({tag, "_vectors"}, 64'(bad_vec), 64'd0);
        check({tag, "_busy324"}, 64'(bad_busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done"}, {62'd0, done2, busy2}, 64'b10);
        check({tag, "_pass"}, 64'(pass2), 64'd1);
        check({tag, "_err"}, 64'(err2), 64'd0);
        check({tag, "_first_fail"}, 64'(ff2), 64'hFFFF);
    endtask

    initial begin
        logic [63:0] model_state;
        int          n_done;
        bit          seen;
        rst_n1 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        mode1  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {if1.dut_a, if1.dut_b, if1.dut_cin, busy1, done1, pass1},
              {4'h0, 4'h0, 1'b0, 3'b000});
        check("reset_err", 64'(err1), 64'd0);
        check("reset_first_fail", 64'(ff1), 64'hFFFF);
        @(negedge clk);
        rst_n1 = 1'b1; rst_n2 = 1'b1; rst_n3 = 1'b1;

        // Long saturating run proceeds in the background.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;

        run_small(0, "good", 16'd0, 16'hFFFF, 1'b1);
        run_small(1, "c_stuck0", 16'd5, 16'd2, 1'b0);
        run_small(2, "s0_inv", 16'd4, 16'd1, 1'b0);

        // Restart at vector 3 is ignored; reset at vector 5 aborts the run.
        mode1 = 0;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("restart_ignored", 64'({if1.dut_a, if1.dut_b, if1.dut_cin, busy1}),
              64'({small_vec(4), 1'b1}));
        @(posedge clk); #1;
        check("vector5", 64'({if1.dut_a, if1.dut_b, if1.dut_cin}), 64'(small_vec(5)));
        #2 rst_n1 = 1'b0;
        #1;
        check("abort_outputs", {if1.dut_a, if1.dut_b, if1.dut_cin, busy1, done1, pass1},
              {4'h0, 4'h0, 1'b0, 3'b000});
        check("abort_err", 64'(err1), 64'd0);
        check("abort_first_fail", 64'(ff1), 64'hFFFF);
        n_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done1) n_done++;
        end
        @(negedge clk) rst_n1 = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done1 || busy1) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        run_small(0, "after_abort", 16'd0, 16'hFFFF, 1'b1);

        // Wide run, then reset and repeat: the PRNG sequence must restart.
        model_state = 64'h9E3779B97F4A7C15;
        run_wide("wide_run1", model_state);
        @(negedge clk) rst_n2 = 1'b0;
        @(negedge clk) rst_n2 = 1'b1;
        model_state = 64'h9E3779B97F4A7C15;
        run_wide("wide_run2", model_state);

        // Saturating run completion.
        seen = 1'b0;
        for (int c = 0; c < 70000 && !seen; c++) begin
            @(posedge clk); #1;
            if (done3) seen = 1'b1;
        end
        check("sat_done_seen", 64'(seen), 64'd1);
        check("sat_err", 64'(err3), 64'hFFFF);
        check("sat_first_fail", 64'(ff3), 64'd0);
        check("sat_pass", 64'(pass3), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adder_bist.md
# adder_bist

Built-in self-test engine for the team's N-bit adders (full_adder / ripple-carry chain). It drives the adder-under-test's a/b/cin inputs, waits a fixed settle time, checks the returned sum/carry against an internal golden a+b+cin, and reports pass/fail with error statistics. It replaces the hand-written stimulus in adder testbenches and runs on the FPGA next to the adder.

## Interface
- WIDTH, 64: operand width of the adder under test; legal 1..64
- SETTLE, 1: clock cycles each vector is held before its result is sampled; legal 1..15
- NUM_RANDOM, 256: pseudo-random vectors applied after the corner set; legal 0..65527
- SEED, 64'h9E3779B97F4A7C15: PRNG seed; 0 is replaced by the default

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- dut_a  out  WIDTH  operand a to the adder
- dut_b  out  WIDTH  operand b to the adder
- dut_cin  out  1  carry-in to the adder
- dut_s  in  WIDTH  sum returned by the adder
- dut_c  in  1  carry-out returned by the adder
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last run had zero mismatches; held until next start
- err_count  out  16  mismatches in last run, saturating at 16'hFFFF
- first_fail  out  16  index of first failing vector; 16'hFFFF if none

## Operation
- Reset values: dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, err_count=0, first_fail=16'hFFFF; FSM in IDLE; PRNG reloaded with SEED.
- FSM states: IDLE, CORNER, RANDOM.
  - IDLE + start: load vector 0, clear err_count and first_fail, set busy and pass=0, go to CORNER.
  - CORNER: eight fixed vectors, indices 0-7: (0,0,0), (0,0,1), (ones,0,1), (ones,ones,1), (ones,ones,0), (0xAA..,0x55..,0), (0xAA..,0x55..,1), (msb,msb,0). Here ones is all-ones, 0xAA../0x55.. are alternating patterns truncated to WIDTH, and msb is 1<<(WIDTH-1). After index 7: go to RANDOM if NUM_RANDOM>0, else finish.
  - RANDOM: indices 8 .. 7+NUM_RANDOM. Each vector advances a 64-bit xorshift twice (x^=x<<13; x^=x>>7; x^=x<<17). a is the low WIDTH bits of the first step. b is the low WIDTH bits of the second step. cin is bit 63 of the second step.
  - Finish: return to IDLE, busy=0, done=1 for one cycle, pass=(err_count==0 after final check).
- Check: the golden value is the (WIDTH+1)-bit sum a+b+cin. A vector mismatches when {dut_c,dut_s} differs from golden. On mismatch, err_count increments (saturating). first_fail records the vector index only if it is still 16'hFFFF.
- start is ignored while busy. A start arriving on the done cycle is ignored; the next start is accepted in IDLE.
- PRNG state persists across runs; it is reloaded with SEED only on reset.

## Timing
- Vector i is loaded on edge L_i. Operands are stable for exactly SETTLE cycles. The result is sampled on edge L_i+SETTLE, and the same edge loads vector i+1, so the vector period is SETTLE cycles.
- start sampled on edge k loads vector 0 on edge k. The final sample is on edge k+N·SETTLE, with N=8+NUM_RANDOM. busy falls and done rises on that edge, and pass, err_count and first_fail are final there.
- dut_a, dut_b and dut_cin hold their last vector after the run ends.
- Asserting rst_n low mid-run immediately forces all reset values and returns the FSM to IDLE; no done pulse is produced.

## Structure
- Package adder_bist_pkg contains:
  - state enum (IDLE, CORNER, RANDOM)
  - NUM_CORNER=8
  - NO_FAIL=16'hFFFF
  - xorshift shift constants 13/7/17
  - DEFAULT_SEED
- Sub-module adder_bist_prng: 64-bit xorshift with a load input (seed) and an advance strobe; it outputs two successive states per advance.
- The golden adder is a behavioural '+' in the top level; it does not reuse the adder under test.

## Test plan
- WIDTH=4, SETTLE=1, NUM_RANDOM=0, correct adder; start on edge k → busy high for 8 cycles, done pulse after edge k+8, pass=1, err_count=0, first_fail=16'hFFFF.
- Same configuration, adder with dut_c stuck at 0 → err_count=5, first_fail=2, pass=0.
- Same configuration, adder inverting sum bit 0 whenever cin=1 → err_count=4, first_fail=1.
- WIDTH=64, SETTLE=3, NUM_RANDOM=100, correct adder; operands must change only every 3 cycles → done 324 cycles after start, pass=1. Two runs after reset give identical dut_a/dut_b sequences.
- Pulse start again at vector 3, then pull rst_n low at vector 5 → second start has no effect. Reset gives all outputs at reset values, no done pulse, and a fresh start then completes normally.
- WIDTH=8, always-wrong adder, NUM_RANDOM=65527 → err_count saturates at 16'hFFFF, first_fail=0.
